sipo_loader: RTL and testbench

//   Serial-in/parallel-out front end for the N-bit PIPO register d_ffN.
//   - Deserialises a framed bit stream into an N-bit word.
//   - Presents the word on DATA together with a one-cycle LOAD strobe.
//   - DATA drives the PIPO D input; LOAD drives the PIPO EN input.
//   - The PIPO therefore captures exactly one complete word per frame.
//

---
 rtl/sipo_loader.sv | 134 +++++++++++++
 tb/tb_sipo_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out front end: assembles a framed bit stream into an N-bit word
// and strobes LOAD for one cycle so a downstream PIPO register (d_ffN) captures it.

module sipo_loader #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   SIN,
    input  logic                   SVALID,
    output logic [N-1:0]           DATA,
    output logic                   LOAD,
    output logic                   BUSY,
    output logic [$clog2(N+1)-1:0] COUNT
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LDOUT = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  sr_shifted;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[N-2:0], SIN};
        end else begin
            sr_shifted = {SIN, sr_q[N-1:1]};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here is how latches get inferred.
        state_d = state_q;
        sr_d    = sr_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SHIFT;
                    sr_d    = '0;
                    count_d = '0;
                end
            end

            S_SHIFT: begin
                // START outranks SVALID: restart the frame and drop the coincident bit.
                if (START) begin
                    sr_d    = '0;
                    count_d = '0;
                end else if (SVALID) begin
                    sr_d = sr_shifted;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + 1'b1;
                    end
                    if (count_q == CNT_LAST) begin
                        state_d = S_LDOUT;
                    end
                end
            end

            S_LDOUT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            count_q <= count_d;
        end
    end

    assign DATA  = sr_q;
    assign LOAD  = (state_q == S_LDOUT);
    assign BUSY  = (state_q == S_SHIFT);
    assign COUNT = count_q;

endmodule

// Downstream N-bit PIPO register with enable and asynchronous active-low reset.
module d_ffN #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         EN,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Bench for sipo_loader: an LSB-first and an MSB-first loader share one stimulus
// stream, each feeding a d_ffN; a scoreboard queue holds the words each LOAD must present.

module tb_sipo_loader;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [N-1:0] lsb;
        logic [N-1:0] msb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, sin, svalid;
    logic [N-1:0]  data0, data1, q0, q1;
    logic          load0, load1, busy0, busy1;
    logic [CW-1:0] count0, count1;

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;

    exp_t         sb[$];
    logic         pipo_pend = 1'b0;
    exp_t         pipo_exp;
    logic         prev_load = 1'b0;

    always #5 clk = ~clk;

    sipo_loader #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RESET(rst), .START(start), .SIN(sin), .SVALID(svalid),
        .DATA(data0), .LOAD(load0), .BUSY(busy0), .COUNT(count0)
    );

    sipo_loader #(.N(N), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RESET(rst), .START(start), .SIN(sin), .SVALID(svalid),
        .DATA(data1), .LOAD(load1), .BUSY(busy1), .COUNT(count1)
    );

    d_ffN #(.N(N)) u_pipo0 (.CLK(clk), .N_RESET(~rst), .EN(load0), .D(data0), .Q(q0));
    d_ffN #(.N(N)) u_pipo1 (.CLK(clk), .N_RESET(~rst), .EN(load1), .D(data1), .Q(q1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each LOAD, then checks the PIPO one edge later.
    always @(negedge clk) begin
        if (pipo_pend) begin
            check("pipo_q_lsb", q0, pipo_exp.lsb);
            check("pipo_q_msb", q1, pipo_exp.msb);
            pipo_pend = 1'b0;
        end
        if (load0) begin
            load_cnt++;
            check("load_single_cycle", prev_load, 1'b0);
            check("load_msb_aligned", load1, 1'b1);
            check("busy_low_in_load", busy0, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_load", 1'b1, 1'b0);
            end else begin
                pipo_exp = sb.pop_front();
                check("data_lsb", data0, pipo_exp.lsb);
                check("data_msb", data1, pipo_exp.msb);
                pipo_pend = 1'b1;
            end
        end
        prev_load = load0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy0, 1'b1);
        check("start_count", count0, 0);
        check("start_data", data0, 0);
    endtask

    // Sends word bits in order word[0]..word[N-1], with 'gap' idle cycles before each.
    task automatic send_bits(input logic [N-1:0] word, input int gap);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_count_hold", count0, i);
            end
            sin    = word[i];
            svalid = 1'b1;
            tick();
            svalid = 1'b0;
            check("count_step", count0, i + 1);
        end
        check("ldout_load", load0, 1'b1);
        check("ldout_busy", busy0, 1'b0);
        check("ldout_count", count0, N);
    endtask

    task automatic send_frame(input logic [N-1:0] lsb, input logic [N-1:0] msb, input int gap);
        sb.push_back('{lsb: lsb, msb: msb});
        pulse_start();
        send_bits(lsb, gap);
        tick();
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sin    = 1'b0;
        svalid = 1'b0;

        // Reset asserted before any clock edge.
        #2;
        check("rst_data", data0, 0);
        check("rst_load", load0, 0);
        check("rst_busy", busy0, 0);
        check("rst_count", count0, 0);
        check("rst_pipo", q0, 0);
        #6 rst = 1'b0;
        tick();

        // Back-to-back contiguous frame, then the same frame with 2-cycle gaps.
        send_frame(8'h96, 8'h69, 0);
        send_frame(8'h96, 8'h69, 2);

        // Abort after 3 bits with START coinciding with a valid '1' bit.
        sb.push_back('{lsb: 8'h3C, msb: 8'h3C});
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            sin = 1'b1; svalid = 1'b1; tick();
        end
        svalid = 1'b0;
        check("pre_abort_count", count0, 3);
        start = 1'b1; svalid = 1'b1; sin = 1'b1;
        tick();
        start = 1'b0; svalid = 1'b0;
        check("abort_count", count0, 0);
        check("abort_data", data0, 0);
        check("abort_busy", busy0, 1'b1);
        send_bits(8'h3C, 0);
        tick();
        tick();

        // Asynchronous reset mid-frame, checked before the next edge.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            sin = 1'b1; svalid = 1'b1; tick();
        end
        svalid = 1'b0;
        check("pre_rst_data", data0, 8'hF8);
        rst = 1'b1;
        #1;
        check("arst_data", data0, 0);
        check("arst_data_msb", data1, 0);
        check("arst_count", count0, 0);
        check("arst_busy", busy0, 0);
        check("arst_load", load0, 0);
        check("arst_pipo", q0, 0);
        #1 rst = 1'b0;
        tick();
        send_frame(8'hFF, 8'hFF, 0);

        // SVALID in IDLE is ignored; DATA holds the last word.
        sin = 1'b0; svalid = 1'b1;
        tick();
        svalid = 1'b0;
        check("idle_svalid_data", data0, 8'hFF);
        check("idle_svalid_busy", busy0, 1'b0);

        // START and SVALID during LDOUT are ignored.
        sb.push_back('{lsb: 8'hA5, msb: 8'hA5});
        pulse_start();
        send_bits(8'hA5, 0);
        start = 1'b1; svalid = 1'b1; sin = 1'b0;
        tick();
        start = 1'b0; svalid = 1'b0;
        check("ldout_start_ignored", busy0, 1'b0);
        check("ldout_svalid_data", data0, 8'hA5);
        check("ldout_svalid_data_msb", data1, 8'hA5);
        check("ldout_count_hold", count0, N);

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        check("load_total", load_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
